mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port main memory of the multi-cycle CPU. Port 0 serves the CPU control/datapath (fetch, LW, SW); port 1 serves the program loader/debug port. The block grants one requester at a time round-robin, drives the memory for one access, waits a fixed number of wait states, then returns read data with a one-cycle acknowledge. It sits between the CPU controller's memory strobes and the memory array.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the single-port memory.
// The slave view is the arbiter; the master view is its surroundings (requesters plus memory).
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          Req0;
    logic          Req1;
    logic          We0;
    logic          We1;
    logic [AW-1:0] Addr0;
    logic [AW-1:0] Addr1;
    logic [DW-1:0] WData0;
    logic [DW-1:0] WData1;
    logic          Ack0;
    logic          Ack1;
    logic [DW-1:0] RData;
    logic [1:0]    Grant;
    logic          Busy;
    logic          Mem_En;
    logic          Mem_We;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_WData;
    logic [DW-1:0] Mem_RData;
    logic [1:0]    Stateout;

    modport slave (
        input  Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1, Mem_RData,
        output Ack0, Ack1, RData, Grant, Busy, Mem_En, Mem_We, Mem_Addr, Mem_WData, Stateout
    );

    modport master (
        output Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1, Mem_RData,
        input  Ack0, Ack1, RData, Grant, Busy, Mem_En, Mem_We, Mem_Addr, Mem_WData, Stateout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the CPU's single-port main memory.
// One access per grant: IDLE -> ISSUE -> WAIT x WAIT_CYCLES -> DONE (Ack) -> IDLE.
module mem_port_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    mem_port_arbiter_if.slave    bus
);
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ISSUE = 2'b01;
    localparam logic [1:0] S_WAIT  = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]    r_state;
    logic [1:0]    r_grant;
    logic          r_last_grant;   // index of the last winner; 1 after reset so port 0 wins the first tie
    logic          r_we_latch;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_rdata;
    logic [3:0]    r_wait_cnt;

    logic          w_req_any;
    logic          w_pick;
    logic [1:0]    w_next_state;
    logic          w_last_wait;
    logic          w_capture;

    assign w_req_any   = bus.Req0 | bus.Req1;
    assign w_last_wait = (r_state == S_WAIT) && (r_wait_cnt <= 4'd1);
    assign w_capture   = !r_we_latch &&
                         (((r_state == S_ISSUE) && (WAIT_LOAD == 4'd0)) || w_last_wait);

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_pick = 1'b0;
        if (bus.Req0 && bus.Req1) begin
            w_pick = ~r_last_grant;
        end else if (bus.Req1) begin
            w_pick = 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_req_any) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = (WAIT_LOAD == 4'd0) ? S_DONE : S_WAIT;
            S_WAIT:  if (w_last_wait) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_grant      <= 2'b00;
            r_last_grant <= 1'b1;
            r_we_latch   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rdata      <= '0;
            r_wait_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_grant      <= w_pick ? 2'b10 : 2'b01;
                        r_last_grant <= w_pick;
                        r_we_latch   <= w_pick ? bus.We1    : bus.We0;
                        r_mem_addr   <= w_pick ? bus.Addr1  : bus.Addr0;
                        r_mem_wdata  <= w_pick ? bus.WData1 : bus.WData0;
                    end
                end
                S_ISSUE: r_wait_cnt <= WAIT_LOAD;
                S_WAIT:  r_wait_cnt <= r_wait_cnt - 4'd1;
                S_DONE:  r_grant    <= 2'b00;
                default: r_grant    <= 2'b00;
            endcase
            // Writes leave the previous read data visible on RData.
            if (w_capture) begin
                r_rdata <= bus.Mem_RData;
            end
        end
    end

    assign bus.Ack0      = (r_state == S_DONE) && r_grant[0];
    assign bus.Ack1      = (r_state == S_DONE) && r_grant[1];
    assign bus.RData     = r_rdata;
    assign bus.Grant     = r_grant;
    assign bus.Busy      = (r_state != S_IDLE);
    assign bus.Mem_En    = (r_state == S_ISSUE);
    assign bus.Mem_We    = (r_state == S_ISSUE) && r_we_latch;
    assign bus.Mem_Addr  = r_mem_addr;
    assign bus.Mem_WData = r_mem_wdata;
    assign bus.Stateout  = r_state;

    a_ack_exclusive: assert property (@(posedge Clk) disable iff (Reset) !(bus.Ack0 && bus.Ack1));
    a_grant_onehot:  assert property (@(posedge Clk) disable iff (Reset) $onehot0(r_grant));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: WAIT_CYCLES=1 instance with a block-RAM model,
// plus WAIT_CYCLES=0 and WAIT_CYCLES=3 instances with combinational-read memories.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst0, rst1, rst3;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(16), .DW(32)) b0 ();
    mem_port_arbiter_if #(.AW(16), .DW(32)) b1 ();
    mem_port_arbiter_if #(.AW(16), .DW(32)) b3 ();

    mem_port_arbiter #(.AW(16), .DW(32), .WAIT_CYCLES(0)) u_dut0 (.Clk(clk), .Reset(rst0), .bus(b0.slave));
    mem_port_arbiter #(.AW(16), .DW(32), .WAIT_CYCLES(1)) u_dut1 (.Clk(clk), .Reset(rst1), .bus(b1.slave));
    mem_port_arbiter #(.AW(16), .DW(32), .WAIT_CYCLES(3)) u_dut3 (.Clk(clk), .Reset(rst3), .bus(b3.slave));

    // Synchronous-read RAM for the one-wait-state instance; word 0x10 preloaded while in reset.
    logic [31:0] mem1 [256];
    always @(posedge clk) begin
        if (rst1) begin
            mem1[8'h10] <= 32'hDEADBEEF;
        end else if (b1.Mem_En) begin
            if (b1.Mem_We) mem1[b1.Mem_Addr[7:0]] <= b1.Mem_WData;
            b1.Mem_RData <= mem1[b1.Mem_Addr[7:0]];
        end
    end

    logic [31:0] mem0 [256];
    logic [31:0] mem3 [256];
    initial begin
        mem0[8'h20] = 32'hA5A50001;
        mem3[8'h30] = 32'h0BADF00D;
    end
    assign b0.Mem_RData = mem0[b0.Mem_Addr[7:0]];
    assign b3.Mem_RData = mem3[b3.Mem_Addr[7:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [1:0] seq0 [4];
    logic [1:0] seq3 [7];
    logic [1:0] exp_ack;

    initial begin
        seq0 = '{2'd0, 2'd1, 2'd3, 2'd0};
        seq3 = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        {b0.Req0, b0.Req1, b0.We0, b0.We1} = '0;
        {b1.Req0, b1.Req1, b1.We0, b1.We1} = '0;
        {b3.Req0, b3.Req1, b3.We0, b3.We1} = '0;
        b0.Addr0 = '0; b0.Addr1 = '0; b0.WData0 = '0; b0.WData1 = '0;
        b1.Addr0 = '0; b1.Addr1 = '0; b1.WData0 = '0; b1.WData1 = '0;
        b3.Addr0 = '0; b3.Addr1 = '0; b3.WData0 = '0; b3.WData1 = '0;
        rst0 = 1'b1; rst1 = 1'b1; rst3 = 1'b1;
        tick(); tick();

        // Reset values
        check("rst_state", b1.Stateout, 2'b00);
        check("rst_busy",  b1.Busy, 1'b0);
        check("rst_grant", b1.Grant, 2'b00);
        check("rst_acks",  {b1.Ack1, b1.Ack0}, 2'b00);
        check("rst_memen", {b1.Mem_En, b1.Mem_We}, 2'b00);
        check("rst_maddr", b1.Mem_Addr, 16'h0000);
        check("rst_mwdat", b1.Mem_WData, 32'h0);
        check("rst_rdata", b1.RData, 32'h0);
        check("rst_st0",   b0.Stateout, 2'b00);
        check("rst_st3",   b3.Stateout, 2'b00);
        rst0 = 1'b0; rst1 = 1'b0; rst3 = 1'b0;

        // Port 0 read of 0x0010 (cycle 0 = IDLE arbitration cycle)
        b1.Req0 = 1'b1; b1.We0 = 1'b0; b1.Addr0 = 16'h0010;
        tick();
        check("rd_c1_state", b1.Stateout, 2'b01);
        check("rd_c1_en",    {b1.Mem_En, b1.Mem_We}, 2'b10);
        check("rd_c1_addr",  b1.Mem_Addr, 16'h0010);
        check("rd_c1_grant", b1.Grant, 2'b01);
        check("rd_c1_busy",  b1.Busy, 1'b1);
        b1.Addr0 = 16'h0077;
        tick();
        check("rd_c2_state", b1.Stateout, 2'b10);
        check("rd_c2_en",    b1.Mem_En, 1'b0);
        check("rd_c2_addr",  b1.Mem_Addr, 16'h0010);
        check("rd_c2_grant", b1.Grant, 2'b01);
        tick();
        check("rd_c3_state", b1.Stateout, 2'b11);
        check("rd_c3_acks",  {b1.Ack1, b1.Ack0}, 2'b01);
        check("rd_c3_rdata", b1.RData, 32'hDEADBEEF);
        check("rd_c3_grant", b1.Grant, 2'b01);
        b1.Req0 = 1'b0;
        tick();
        check("rd_c4_state", b1.Stateout, 2'b00);
        check("rd_c4_acks",  {b1.Ack1, b1.Ack0}, 2'b00);
        check("rd_c4_grant", b1.Grant, 2'b00);
        check("rd_c4_busy",  b1.Busy, 1'b0);
        check("rd_c4_rdata", b1.RData, 32'hDEADBEEF);

        // Port 1 write of 0x12345678 to 0x0004
        b1.Req1 = 1'b1; b1.We1 = 1'b1; b1.Addr1 = 16'h0004; b1.WData1 = 32'h12345678;
        tick();
        check("wr_c1_en",    {b1.Mem_En, b1.Mem_We}, 2'b11);
        check("wr_c1_addr",  b1.Mem_Addr, 16'h0004);
        check("wr_c1_wdata", b1.Mem_WData, 32'h12345678);
        check("wr_c1_grant", b1.Grant, 2'b10);
        tick();
        check("wr_c2_en",    {b1.Mem_En, b1.Mem_We}, 2'b00);
        tick();
        check("wr_c3_acks",  {b1.Ack1, b1.Ack0}, 2'b10);
        check("wr_c3_rdata", b1.RData, 32'hDEADBEEF);
        b1.Req1 = 1'b0; b1.We1 = 1'b0;
        tick();
        check("wr_c4_acks",  {b1.Ack1, b1.Ack0}, 2'b00);

        // Port 0 reads back the written word
        b1.Req0 = 1'b1; b1.Addr0 = 16'h0004;
        tick(); tick(); tick();
        check("rb_c3_acks",  {b1.Ack1, b1.Ack0}, 2'b01);
        check("rb_c3_rdata", b1.RData, 32'h12345678);
        b1.Req0 = 1'b0;
        tick();

        // Simultaneous held requests after reset: 0,1,0,1 with Acks 4 cycles apart
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        b1.Req0 = 1'b1; b1.Addr0 = 16'h0010;
        b1.Req1 = 1'b1; b1.Addr1 = 16'h0004; b1.We1 = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            exp_ack = 2'b00;
            if (c % 4 == 3) exp_ack = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
            check($sformatf("rr_c%0d_acks", c), {b1.Ack1, b1.Ack0}, exp_ack);
            check($sformatf("rr_c%0d_en", c), b1.Mem_En, (c % 4 == 1) ? 1'b1 : 1'b0);
            if (exp_ack == 2'b01) check($sformatf("rr_c%0d_rd0", c), b1.RData, 32'hDEADBEEF);
            if (exp_ack == 2'b10) check($sformatf("rr_c%0d_rd1", c), b1.RData, 32'h12345678);
            if (c == 15) begin
                b1.Req0 = 1'b0; b1.Req1 = 1'b0;
            end
        end
        tick();
        check("rr_end_busy", b1.Busy, 1'b0);

        // Reset during WAIT of a port 1 read aborts it with no Ack
        b1.Req1 = 1'b1; b1.We1 = 1'b0; b1.Addr1 = 16'h0010;
        tick();
        check("ab_c1_grant", b1.Grant, 2'b10);
        tick();
        check("ab_c2_state", b1.Stateout, 2'b10);
        rst1 = 1'b1; b1.Req1 = 1'b0;
        tick();
        check("ab_c3_state", b1.Stateout, 2'b00);
        check("ab_c3_busy",  b1.Busy, 1'b0);
        check("ab_c3_acks",  {b1.Ack1, b1.Ack0}, 2'b00);
        check("ab_c3_grant", b1.Grant, 2'b00);
        check("ab_c3_rdata", b1.RData, 32'h0);
        rst1 = 1'b0;
        tick();
        check("ab_c4_acks",  {b1.Ack1, b1.Ack0}, 2'b00);

        // Tie after reset goes to port 0; Req0 dropped in ISSUE, Req1 raised during WAIT
        b1.Req0 = 1'b1; b1.Addr0 = 16'h0010; b1.We0 = 1'b0;
        b1.Req1 = 1'b1; b1.Addr1 = 16'h0004;
        tick();
        check("dr_c1_grant", b1.Grant, 2'b01);
        b1.Req0 = 1'b0; b1.Req1 = 1'b0;
        tick();
        b1.Req1 = 1'b1;
        check("dr_c2_grant", b1.Grant, 2'b01);
        tick();
        check("dr_c3_acks",  {b1.Ack1, b1.Ack0}, 2'b01);
        check("dr_c3_rdata", b1.RData, 32'hDEADBEEF);
        tick();
        check("dr_c4_state", b1.Stateout, 2'b00);
        check("dr_c4_grant", b1.Grant, 2'b00);
        tick();
        check("dr_c5_state", b1.Stateout, 2'b01);
        check("dr_c5_grant", b1.Grant, 2'b10);
        check("dr_c5_addr",  b1.Mem_Addr, 16'h0004);
        tick(); tick();
        check("dr_c7_acks",  {b1.Ack1, b1.Ack0}, 2'b10);
        check("dr_c7_rdata", b1.RData, 32'h12345678);
        b1.Req1 = 1'b0;
        tick();
        check("dr_c8_busy",  b1.Busy, 1'b0);

        // WAIT_CYCLES=0: 00,01,11,00 with Ack at cycle 2
        check("w0_c0_state", b0.Stateout, seq0[0]);
        b0.Req0 = 1'b1; b0.Addr0 = 16'h0020;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("w0_c%0d_state", i), b0.Stateout, seq0[i]);
            check($sformatf("w0_c%0d_ack", i), b0.Ack0, (i == 2) ? 1'b1 : 1'b0);
            if (i == 2) begin
                check("w0_rdata", b0.RData, 32'hA5A50001);
                b0.Req0 = 1'b0;
            end
        end

        // WAIT_CYCLES=3: 00,01,10,10,10,11,00 with Ack at cycle 5
        check("w3_c0_state", b3.Stateout, seq3[0]);
        b3.Req0 = 1'b1; b3.Addr0 = 16'h0030;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("w3_c%0d_state", i), b3.Stateout, seq3[i]);
            check($sformatf("w3_c%0d_ack", i), b3.Ack0, (i == 5) ? 1'b1 : 1'b0);
            if (i == 5) begin
                check("w3_rdata", b3.RData, 32'h0BADF00D);
                b3.Req0 = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
